// File: rtl/rs_hs_pipeline_tail.sv
// Tail of a pipelined valid/ready channel: absorbs in-flight beats in an
// almost-full FIFO and presents a first-word-fall-through read interface.
module rs_hs_pipeline_tail #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PIPELINE_LEVEL = 2,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              if_din,
  input  logic                               if_write,
  output logic                               if_full_n,
  output logic [DATA_WIDTH-1:0]              if_dout,
  output logic                               if_empty_n,
  input  logic                               if_read,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy,
  output logic                               overflow_err
);

  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned GRACE  = 2 * PIPELINE_LEVEL + 1;
  localparam int unsigned THRESH = FIFO_DEPTH - GRACE;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_next;
  logic [PW-1:0]         rd_ptr_next;
  logic                  wr_en;
  logic                  rd_en;
  logic                  full;
  logic                  empty;
  logic                  overflow_hit;
  logic [DATA_WIDTH-1:0] head_next;

  // Enables, next pointers/count, and the head entry as seen after this edge
  always_comb begin
    full         = (count == CW'(FIFO_DEPTH));
    empty        = (count == '0);
    rd_en        = if_read && !empty;
    wr_en        = if_write && (!full || rd_en);
    overflow_hit = if_write && full && !rd_en;
    count_next   = count + CW'(wr_en) - CW'(rd_en);

    wr_ptr_next = wr_ptr;
    if (wr_en) begin
      wr_ptr_next = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    end
    rd_ptr_next = rd_ptr;
    if (rd_en) begin
      rd_ptr_next = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end

    // A beat written into the slot that becomes the head bypasses storage
    head_next = (wr_en && (wr_ptr == rd_ptr_next)) ? if_din : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= if_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      if_full_n    <= 1'b0;
      if_empty_n   <= 1'b0;
      if_dout      <= '0;
      overflow_err <= 1'b0;
    end else begin
      count        <= count_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      if_full_n    <= (count_next < CW'(THRESH));
      if_empty_n   <= (count_next != '0);
      if_dout      <= head_next;
      overflow_err <= overflow_err || overflow_hit;
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_rs_hs_pipeline_tail.sv
// Directed self-checking bench for rs_hs_pipeline_tail at default parameters.
`timescale 1ns/1ps
module tb_rs_hs_pipeline_tail;

  logic        clk;
  logic        reset;
  logic [31:0] if_din;
  logic        if_write;
  logic        if_full_n;
  logic [31:0] if_dout;
  logic        if_empty_n;
  logic        if_read;
  logic [4:0]  occupancy;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  rs_hs_pipeline_tail #(
    .DATA_WIDTH(32),
    .PIPELINE_LEVEL(2),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_din(if_din),
    .if_write(if_write),
    .if_full_n(if_full_n),
    .if_dout(if_dout),
    .if_empty_n(if_empty_n),
    .if_read(if_read),
    .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = 32'h0;

    // Reset with a write attempt that must be ignored
    step(1'b1, 32'hAAAA, 1'b0);
    step(1'b1, 32'hBBBB, 1'b0);
    chk("rst_full_n", 32'(if_full_n), 32'd0);
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_dout", if_dout, 32'h0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);

    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk("post_rst_full_n", 32'(if_full_n), 32'd1);
    chk("post_rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    // Fill to THRESH=11
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 1) begin
        chk("first_empty_n", 32'(if_empty_n), 32'd1);
        chk("first_dout", if_dout, 32'h1);
      end
      if (i == 10) chk("full_n_at_10", 32'(if_full_n), 32'd1);
    end
    chk("full_n_at_11", 32'(if_full_n), 32'd0);
    chk("occ_11", 32'(occupancy), 32'd11);

    // Grace window beats
    for (int i = 12; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
    chk("occ_16", 32'(occupancy), 32'd16);
    chk("ovf_grace", 32'(overflow_err), 32'd0);
    chk("full_n_16", 32'(if_full_n), 32'd0);

    // Overflow: beat dropped, sticky error
    step(1'b1, 32'hDEAD, 1'b0);
    chk("ovf_occ", 32'(occupancy), 32'd16);
    chk("ovf_set", 32'(overflow_err), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_dout_%0d", i), if_dout, 32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("drain_empty_n", 32'(if_empty_n), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    chk("drain_full_n", 32'(if_full_n), 32'd1);

    do_reset();
    chk("ovf_cleared", 32'(overflow_err), 32'd0);

    // Simultaneous read and write at full
    for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    chk("full2_occ", 32'(occupancy), 32'd16);
    chk("rw_full_head", if_dout, 32'h100);
    step(1'b1, 32'hBEEF, 1'b1);
    chk("rw_full_occ", 32'(occupancy), 32'd16);
    chk("rw_full_ovf", 32'(overflow_err), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("rw_drain_%0d", i), if_dout, (i == 16) ? 32'hBEEF : 32'h100 + 32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("rw_drain_occ", 32'(occupancy), 32'd0);
    chk("rw_drain_empty_n", 32'(if_empty_n), 32'd0);

    // Empty boundary
    step(1'b0, 32'h0, 1'b1);
    chk("empty_rd_occ", 32'(occupancy), 32'd0);
    chk("empty_rd_empty_n", 32'(if_empty_n), 32'd0);
    step(1'b1, 32'h55, 1'b1);
    chk("empty_rw_occ", 32'(occupancy), 32'd1);
    chk("empty_rw_empty_n", 32'(if_empty_n), 32'd1);
    chk("empty_rw_dout", if_dout, 32'h55);
    step(1'b0, 32'h0, 1'b1);
    chk("empty_again_occ", 32'(occupancy), 32'd0);

    // 40-beat stream with reads every cycle; pointers wrap several times
    step(1'b1, 32'h1000, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      chk($sformatf("stream_dout_%0d", i), if_dout, 32'h1000 + 32'(i - 1));
      chk($sformatf("stream_full_n_%0d", i), 32'(if_full_n), 32'd1);
      step(1'b1, 32'h1000 + 32'(i), 1'b1);
    end
    chk("stream_occ", 32'(occupancy), 32'd1);
    chk("stream_last", if_dout, 32'h1028);

    // Reset mid-stream at occupancy 7
    for (int i = 0; i < 6; i++) step(1'b1, 32'h2000 + 32'(i), 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd7);
    reset = 1'b1;
    step(1'b1, 32'h3000, 1'b0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("mid_rst_full_n", 32'(if_full_n), 32'd0);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk("after_mid_rst_occ", 32'(occupancy), 32'd0);
    chk("after_mid_rst_full_n", 32'(if_full_n), 32'd1);
    chk("after_mid_rst_empty_n", 32'(if_empty_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
